// File: rtl/sseg_capture.sv
// sseg_capture: watches a multiplexed 8-digit seven-segment display bus and
// rebuilds the displayed frame as one 3-bit glyph code per digit.
// A display value is acted on only after it has been stable for STABLE_CYCLES
// samples. Digits are collected starting from digit 0, and a complete frame is
// published once all eight digits have been seen exactly once.
module sseg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  sseg_i,
    input  logic [7:0]  an_i,
    output logic [23:0] frame_o,
    output logic [7:0]  digit_valid_o,
    output logic        frame_done_o,
    output logic        err_o,
    output logic [7:0]  err_count_o
);

    typedef enum logic {
        SYNC,
        COLLECT
    } state_e;

    // Glyph codes. The code for an unknown pattern is still stored.
    localparam logic [2:0] CODE_DASH    = 3'd0;
    localparam logic [2:0] CODE_N       = 3'd1;
    localparam logic [2:0] CODE_ONE     = 3'd2;
    localparam logic [2:0] CODE_EIGHT   = 3'd3;
    localparam logic [2:0] CODE_ZERO    = 3'd4;
    localparam logic [2:0] CODE_SIX     = 3'd5;
    localparam logic [2:0] CODE_BLANK   = 3'd6;
    localparam logic [2:0] CODE_UNKNOWN = 3'd7;

    localparam logic [23:0] BLANK_FRAME = {8{CODE_BLANK}};

    // The stability counter holds (consecutive matching samples - 1) and
    // saturates at STABLE_CYCLES. The accept edge is the one that takes the
    // STABLE_CYCLES-th matching sample. This is the edge where the counter
    // moves from STABLE_CYCLES-2 upward. For STABLE_CYCLES == 1, every new
    // value is accepted on the edge where it first differs from the last sample.
    localparam logic [3:0] STABLE_MAX    = 4'(STABLE_CYCLES);
    localparam logic [3:0] ACCEPT_AT     = (STABLE_CYCLES >= 2) ? 4'(STABLE_CYCLES - 2) : 4'd0;
    localparam bit         SINGLE_SAMPLE = (STABLE_CYCLES == 1);

    logic [15:0] sample_q, sample_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;

    state_e      state_q, state_d;
    logic [7:0]  seen_q, seen_d;
    logic [23:0] codes_q, codes_d;
    logic [23:0] frame_q, frame_d;
    logic [7:0]  digit_valid_q, digit_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic [15:0] incoming;
    logic        sample_match;
    logic        accept;
    logic [7:0]  an_low;
    logic        an_one_hot;
    logic [2:0]  digit_idx;
    logic [7:0]  digit_bit;
    logic [2:0]  glyph_code;
    logic        glyph_err;
    logic        store;

    assign incoming = {an_i, sseg_i};

    // Stability tracking: compare the new sample with the previous one and
    // decide whether this edge is the single accept edge of a stable period.
    always_comb begin
        sample_match = (incoming == sample_q);
        sample_d     = incoming;
        if (!sample_match) begin
            stable_cnt_d = 4'd0;
        end else if (stable_cnt_q < STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + 4'd1;
        end else begin
            stable_cnt_d = stable_cnt_q;
        end
        if (SINGLE_SAMPLE) begin
            accept = !sample_match;
        end else begin
            accept = sample_match && (stable_cnt_q == ACCEPT_AT);
        end
    end

    // Anode analysis: find the single active-low digit enable, if there is one.
    always_comb begin
        an_low     = ~an_i;
        an_one_hot = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        digit_idx  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_low[k]) begin
                digit_idx = 3'(k);
            end
        end
        digit_bit = 8'd1 << digit_idx;
    end

    // Glyph decode: map the full cathode pattern, including dp, to a code.
    always_comb begin
        glyph_err = 1'b0;
        case (sseg_i)
            8'hBF:   glyph_code = CODE_DASH;
            8'hC8:   glyph_code = CODE_N;
            8'hF9:   glyph_code = CODE_ONE;
            8'h80:   glyph_code = CODE_EIGHT;
            8'hC0:   glyph_code = CODE_ZERO;
            8'h82:   glyph_code = CODE_SIX;
            8'hFF:   glyph_code = CODE_BLANK;
            default: begin
                glyph_code = CODE_UNKNOWN;
                glyph_err  = 1'b1;
            end
        endcase
    end

    // Frame assembly: decide what an accepted value does to the collection
    // state, the working codes, the published frame and the error flags.
    always_comb begin
        state_d       = state_q;
        seen_d        = seen_q;
        codes_d       = codes_q;
        frame_d       = frame_q;
        digit_valid_d = digit_valid_q;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;
        store         = 1'b0;

        if (accept && (an_i != 8'hFF)) begin
            if (!an_one_hot) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    SYNC: begin
                        // Only digit 0 can start a frame. Other digits are
                        // silently dropped while we look for the frame start.
                        if (digit_idx == 3'd0) begin
                            store   = 1'b1;
                            err_d   = glyph_err;
                            seen_d  = 8'h01;
                            state_d = COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (!seen_q[digit_idx]) begin
                            store = 1'b1;
                            err_d = glyph_err;
                            if ((seen_q | digit_bit) == 8'hFF) begin
                                frame_done_d = 1'b1;
                                seen_d       = 8'h00;
                                state_d      = SYNC;
                            end else begin
                                seen_d = seen_q | digit_bit;
                            end
                        end else if (digit_idx != 3'd0) begin
                            // A digit repeated before the frame closed means
                            // we lost step with the scan, so resynchronise.
                            err_d   = 1'b1;
                            seen_d  = 8'h00;
                            state_d = SYNC;
                        end else begin
                            // Digit 0 again: treat it as the start of a new
                            // frame and carry on collecting from here.
                            err_d  = 1'b1;
                            store  = 1'b1;
                            seen_d = 8'h01;
                        end
                    end
                    default: begin
                        state_d = SYNC;
                        seen_d  = 8'h00;
                    end
                endcase
            end
        end

        for (int k = 0; k < 8; k++) begin
            if (store && (digit_idx == 3'(k))) begin
                codes_d[3*k +: 3] = glyph_code;
                digit_valid_d[k]  = 1'b1;
            end
        end

        if (frame_done_d) begin
            frame_d = codes_d;
        end

        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State register: sampling, the collection FSM and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q      <= 16'hFFFF;
            stable_cnt_q  <= 4'd0;
            state_q       <= SYNC;
            seen_q        <= 8'h00;
            codes_q       <= BLANK_FRAME;
            frame_q       <= BLANK_FRAME;
            digit_valid_q <= 8'h00;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            sample_q      <= sample_d;
            stable_cnt_q  <= stable_cnt_d;
            state_q       <= state_d;
            seen_q        <= seen_d;
            codes_q       <= codes_d;
            frame_q       <= frame_d;
            digit_valid_q <= digit_valid_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_o       = frame_q;
    assign digit_valid_o = digit_valid_q;
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;
    assign err_count_o   = err_count_q;

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 STABLE_CYCLES, default 4: consecutive identical samples needed before a display value is accepted; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sseg  input  8  observed cathode pattern, active-low, bit7..bit0 = h(dp),g,f,e,d,c,b,a.
REQ-005 an  input  8  observed anode enables, active-low, bit i = digit i.
REQ-006 frame  output  24  last complete frame, 3-bit glyph code per digit, digit i at [3i+2:3i].
REQ-007 digit_valid  output  8  bit i set once digit i has been captured since reset.
REQ-008 frame_done  output  1  one-cycle pulse when all 8 digits are collected.
REQ-009 err  output  1  one-cycle pulse on any capture error.
REQ-010 err_count  output  8  error count, saturating at 255.

Function
REQ-011 Input sampling: {an,sseg} registered every cycle; stability counter cleared on mismatch with the previous sample, else incremented, saturating at STABLE_CYCLES.
REQ-012 Accept: fires exactly once per stable period, at the edge where the same {an,sseg} has been sampled on STABLE_CYCLES consecutive edges; no re-fire until the input changes and stabilises again.
REQ-013 Accept with an == 8'hFF: ignored, no state change, no error.
REQ-014 Accept with more than one an bit low: err pulse, err_count+1, nothing stored, state unchanged.
REQ-015 Glyph decode of full 8-bit sseg: 8'hBF->0 ('-'), 8'hC8->1 ('n'), 8'hF9->2 ('1'), 8'h80->3 ('8'), 8'hC0->4 ('0'), 8'h82->5 ('6'), 8'hFF->6 (blank), any other -> 7 plus err pulse and err_count+1 (code 7 still stored).
REQ-016 Working register codes[23:0] holds the latest code per digit; digit_valid[i] set on every store to digit i.
REQ-017 FSM states SYNC and COLLECT, plus an 8-bit seen mask.
REQ-018 SYNC: an accept for digit 0 stores the code, seen=8'h01, and moves to COLLECT; accepts for digits 1..7 are discarded (no store, no error).
REQ-019 COLLECT, digit i not in seen: store the code and set seen[i].
REQ-020 COLLECT, digit i already in seen, i!=0: err pulse, err_count+1, no store, seen cleared, go to SYNC.
REQ-021 COLLECT, digit 0 already in seen: err pulse, err_count+1, store the code, seen=8'h01, stay in COLLECT (restart).
REQ-022 Completion: on the edge where seen would become 8'hFF, frame <= codes including the new store, frame_done=1 for one cycle, seen cleared, go to SYNC.
REQ-023 Simultaneous decode error and frame completion: err and frame_done both pulse on the same cycle; err_count increments once per accept, never more.
REQ-024 Latency: frame, digit_valid, err and frame_done update on the same edge as the accept; no output is combinational from the inputs.

Reset
REQ-025 On rst at any edge: state=SYNC, seen=0, stability counter=0, sample register=16'hFFFF, codes=frame=24'hDB6DB6 (all blank), digit_valid=0, frame_done=0, err=0, err_count=0.
REQ-026 rst asserted mid-frame discards the partial frame; frame is reset to all-blank, not held.
REQ-027 rst overrides all other events on the same edge.

Verification
REQ-028 With STABLE_CYCLES=4, drive 8 digits an=~(1<<i) for i=0..7 with sseg 8'hBF,C8,F9,F9,80,F9,F9,82, each held 6 cycles -> frame_done pulses once after the digit-7 accept; frame code order d0..d7 = 0,1,2,2,3,2,2,5; err_count=0.
REQ-029 Value held 3 cycles and then changed -> no accept, digit_valid unchanged.
REQ-030 an=8'hFC held 6 cycles -> one err pulse, err_count=1, no store.
REQ-031 Digits 0,1,2 captured, then digit 1 again -> err, state SYNC; a following digit 3 is discarded; digit 0 and then 1..7 -> frame_done.
REQ-032 Digit 5 with sseg=8'h00 during a full frame -> err pulses, frame digit 5 = 7, frame_done still pulses.
REQ-033 Force 300 errors -> err_count holds at 255; rst mid-frame -> all outputs at their reset values on the next cycle.
